// File: rtl/datapath_ctrl_pkg.sv
// Shared mode encodings and default timing for the datapath step controller.
// DEF_* values assume the 50 MHz DE0 clock.
package datapath_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_BREAK = 2'b10
    } mode_e;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_RUN_DIV         = 5000000;
    localparam int DEF_CNT_W           = 16;

    // Width of a counter that must hold values 0..n-1.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/datapath_step_controller_if.sv
// Board-side bundle of the step controller: button/switch/breakpoint inputs
// plus the step pulse and display outputs.
interface datapath_step_controller_if #(
    parameter int CNT_W = 16
);
    logic             step_btn_n;
    logic             run_sw;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      address;
    logic             dp_step;
    logic [CNT_W-1:0] step_count;
    logic [1:0]       mode;
    logic             bp_hit;

    modport master (
        output step_btn_n, run_sw, bp_en, bp_addr, address,
        input  dp_step, step_count, mode, bp_hit
    );

    modport slave (
        input  step_btn_n, run_sw, bp_en, bp_addr, address,
        output dp_step, step_count, mode, bp_hit
    );
endinterface

// File: rtl/datapath_step_controller_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the debounced released->pressed edge.
module button_debouncer
    import datapath_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int            CW   = cnt_bits(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter on the inverted button
            sync_p0 <= ~btn_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                level <= sync_p1;
                cnt   <= '0;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/datapath_step_controller.sv
// Generates the one-cycle dp_step clock enable for the LEGv8 datapath:
// single-step, free-run at a divided rate, and halt on address breakpoint.
module datapath_step_controller
    import datapath_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic                      clock,
    input logic                      reset,
    datapath_step_controller_if.slave bus
);
    localparam int            DW       = cnt_bits(RUN_DIV);
    localparam logic [DW-1:0] DIV_TERM = DW'(RUN_DIV - 1);

    mode_e            state;
    logic [DW-1:0]    div;
    logic             dp_step;
    logic [CNT_W-1:0] step_count;
    logic             bp_hit;
    logic             press;
    logic             run_p0, run_p1;
    logic             bp_en_p0, bp_en_p1;
    logic [31:0]      addr_p0, bp_addr_p0;
    logic             bp_match, div_tc, step_ok;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clock (clock),
        .reset (reset),
        .btn_n (bus.step_btn_n),
        .press (press)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_p0   <= 1'b0;
            run_p1   <= 1'b0;
            bp_en_p0 <= 1'b0;
            bp_en_p1 <= 1'b0;
        end else begin
            // stage p0 -> p1: switch synchronizers
            run_p0   <= bus.run_sw;
            run_p1   <= run_p0;
            bp_en_p0 <= bus.bp_en;
            bp_en_p1 <= bp_en_p0;
        end
    end

    // stage p0: registered copies of the datapath and breakpoint addresses
    always_ff @(posedge clock) begin
        addr_p0    <= bus.address;
        bp_addr_p0 <= bus.bp_addr;
    end

    assign bp_match = bp_en_p1 && (addr_p0 == bp_addr_p0);
    assign div_tc   = (div == DIV_TERM);
    // Drop any request landing right after a pulse so dp_step never doubles up.
    assign step_ok  = !dp_step;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= MODE_HALT;
            div        <= '0;
            dp_step    <= 1'b0;
            step_count <= '0;
            bp_hit     <= 1'b0;
        end else begin
            dp_step <= 1'b0;
            unique case (state)
                MODE_HALT: begin
                    if (press && step_ok) begin
                        dp_step    <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end
                    if (run_p1) begin
                        state <= MODE_RUN;
                        div   <= '0;
                    end
                end
                MODE_RUN: begin
                    if (!run_p1) begin
                        state <= MODE_HALT;
                    end else if (div_tc) begin
                        div <= '0;
                        if (bp_match) begin
                            state  <= MODE_BREAK;
                            bp_hit <= 1'b1;
                        end else if (step_ok) begin
                            dp_step    <= 1'b1;
                            step_count <= step_count + 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                MODE_BREAK: begin
                    // A press steps off the breakpoint even if run_sw drops together.
                    if (press && step_ok) begin
                        dp_step    <= 1'b1;
                        step_count <= step_count + 1'b1;
                        state      <= MODE_HALT;
                        bp_hit     <= 1'b0;
                    end else if (!run_p1) begin
                        state  <= MODE_HALT;
                        bp_hit <= 1'b0;
                    end
                end
                default: begin
                    state  <= MODE_HALT;
                    bp_hit <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dp_step    = dp_step;
    assign bus.step_count = step_count;
    assign bus.mode       = state;
    assign bus.bp_hit     = bp_hit;

endmodule
